// File: rtl/sync_upcount_ctrl_pkg.sv
// Shared definitions for the synchronous up-counter controller.
//   state_t      : run FSM state encoding (2 bits, one code unused)
//   DEF_WIDTH    : default counter width
//   DEF_CLR_VAL  : default clear/restart value
package sync_upcount_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_CLR_VAL = 0;

endpackage

// File: rtl/sync_upcount_ctrl_core.sv
// upcount_core: WIDTH-bit count register with clear/load/increment/hold
// controls (priority in that order) and an unsigned >= terminal compare.
//   clk, reset      : clock, async active-low reset (count -> CLR_VAL)
//   clr_i           : force CLR_VAL
//   ld_i            : load load_val_i
//   inc_i           : count + 1 (modulo 2^WIDTH)
//   load_val_i      : load value
//   max_val_i       : terminal value
//   count_o         : registered count
//   at_term_o       : count_o >= max_val_i
module upcount_core
   import sync_upcount_ctrl_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] CLR_VAL = WIDTH'(DEF_CLR_VAL)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic             inc_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic [WIDTH-1:0] max_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             at_term_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i)      count_d = CLR_VAL;
      else if (ld_i)  count_d = load_val_i;
      else if (inc_i) count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= CLR_VAL;
      else        count_q <= count_d;
   end

   assign count_o   = count_q;
   // >= rather than == so a max_val lowered below the count cannot run away
   assign at_term_o = (count_q >= max_val_i);

endmodule

// File: rtl/sync_upcount_ctrl.sv
// sync_upcount_ctrl: up-counter with programmable terminal value, load,
// enable, synchronous clear and free-run / one-shot modes.
//   clk, reset : rising-edge clock, async active-low reset
//   en         : count enable (only effective in RUN)
//   start      : IDLE->RUN, or DONE->RUN restarting from CLR_VAL
//   clear      : counter <= CLR_VAL, state <= IDLE
//   load       : counter <= load_val
//   max_val    : terminal value
//   oneshot    : 1 = stop at terminal (DONE), 0 = wrap to CLR_VAL
//   counter    : registered count
//   carry_out  : combinational ripple carry, RUN & en & counter >= max_val
//   busy, done : registered state decodes (RUN, DONE)
module sync_upcount_ctrl
   import sync_upcount_ctrl_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] CLR_VAL = WIDTH'(DEF_CLR_VAL)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             start,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   input  logic             oneshot,
   output logic [WIDTH-1:0] counter,
   output logic             carry_out,
   output logic             busy,
   output logic             done
);

   state_t state_q;
   logic   busy_q, done_q;
   logic   at_term;
   logic   run_term;
   logic   core_clr, core_ld, core_inc;

   assign run_term = (state_q == ST_RUN) && en && at_term;

   // Clear also covers the DONE restart and the free-run wrap; a load in the
   // same cycle wins over both (loaded value is kept on a start from DONE).
   assign core_clr = clear
                   || (!load && (state_q == ST_DONE) && start)
                   || (!load && run_term && !oneshot);
   assign core_ld  = load;
   assign core_inc = (state_q == ST_RUN) && en && !at_term;

   upcount_core #(
      .WIDTH   (WIDTH),
      .CLR_VAL (CLR_VAL)
   ) u_core (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (core_clr),
      .ld_i       (core_ld),
      .inc_i      (core_inc),
      .load_val_i (load_val),
      .max_val_i  (max_val),
      .count_o    (counter),
      .at_term_o  (at_term)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (clear) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               state_q <= ST_RUN;
               busy_q  <= 1'b1;
            end
            // a load suppresses counting, so it also suppresses termination
            ST_RUN: if (!load && run_term && oneshot) begin
               state_q <= ST_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            ST_DONE: if (start) begin
               state_q <= ST_RUN;
               busy_q  <= 1'b1;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign carry_out = run_term;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
